// File: rtl/guess_pkg.sv
// Shared encodings and constants for the number-guessing game pipeline.
// The state encoding is also consumed by the downstream hint/flag stage.
package guess_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WIN  = 2'b10,
        ST_LOSE = 2'b11
    } state_t;

    localparam int         DEFAULT_MAX_TRIES = 5;
    localparam logic [4:0] DEFAULT_LFSR_SEED = 5'b00001;

    // Feedback taps for x^5 + x^3 + 1 on a left-shifting register.
    localparam int LFSR_TAP_HI = 4;
    localparam int LFSR_TAP_LO = 2;

    function automatic logic [4:0] lfsr_step(input logic [4:0] cur);
        return {cur[3:0], cur[LFSR_TAP_HI] ^ cur[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for a raw push-button followed by a rising-edge detector;
// emits a single-cycle pulse per press no matter how long the button is held.
module btn_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign pulse = sync2_reg & ~prev_reg;

endmodule

// File: rtl/guess_ctrl.sv
// Game-control stage: button conditioning, secret-number LFSR, guess latch,
// remaining-tries counter and the IDLE/PLAY/WIN/LOSE state machine.
module guess_ctrl
    import guess_pkg::*;
#(
    parameter int         MAX_TRIES = DEFAULT_MAX_TRIES,
    parameter logic [4:0] LFSR_SEED = DEFAULT_LFSR_SEED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_guess,
    input  logic [4:0] sw_guess,
    output logic [1:0] state,
    output logic [4:0] userguess,
    output logic [4:0] RnG,
    output logic [2:0] triesLED
);

    localparam logic [2:0] TRIES_FULL = 3'(MAX_TRIES);

    // Index 0 is start, index 1 is guess.
    logic [1:0] btn_raw;
    logic [1:0] btn_pulse;

    assign btn_raw = {btn_guess, btn_start};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            btn_sync u_btn_sync (
                .clk   (clk),
                .reset (reset),
                .btn   (btn_raw[gi]),
                .pulse (btn_pulse[gi])
            );
        end
    endgenerate

    logic start_pulse;
    logic guess_pulse;

    assign start_pulse = btn_pulse[0];
    assign guess_pulse = btn_pulse[1];

    state_t     state_reg;
    logic [4:0] userguess_reg;
    logic [4:0] rng_reg;
    logic [2:0] tries_reg;
    logic [4:0] lfsr_reg;
    logic [4:0] sw_sync1_reg;
    logic [4:0] sw_sync2_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            userguess_reg <= 5'd0;
            rng_reg       <= 5'd0;
            tries_reg     <= TRIES_FULL;
            lfsr_reg      <= LFSR_SEED;
            sw_sync1_reg  <= 5'd0;
            sw_sync2_reg  <= 5'd0;
        end else begin
            lfsr_reg     <= lfsr_step(lfsr_reg);
            sw_sync1_reg <= sw_guess;
            sw_sync2_reg <= sw_sync1_reg;

            // Start outranks guess in every state, so a coincident guess is dropped.
            unique case (state_reg)
                ST_IDLE: begin
                    if (start_pulse) begin
                        rng_reg       <= lfsr_reg;
                        tries_reg     <= TRIES_FULL;
                        userguess_reg <= 5'd0;
                        state_reg     <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (start_pulse) begin
                        state_reg <= ST_IDLE;
                        tries_reg <= TRIES_FULL;
                    end else if (guess_pulse) begin
                        userguess_reg <= sw_sync2_reg;
                        if (sw_sync2_reg == rng_reg) begin
                            state_reg <= ST_WIN;
                        end else if (tries_reg == 3'd1) begin
                            tries_reg <= 3'd0;
                            state_reg <= ST_LOSE;
                        end else begin
                            tries_reg <= tries_reg - 3'd1;
                        end
                    end
                end
                ST_WIN, ST_LOSE: begin
                    if (start_pulse) begin
                        state_reg <= ST_IDLE;
                        tries_reg <= TRIES_FULL;
                    end
                end
            endcase
        end
    end

    assign state     = state_reg;
    assign userguess = userguess_reg;
    assign RnG       = rng_reg;
    assign triesLED  = tries_reg;

endmodule

// File: tb/tb_guess_ctrl.sv
// Randomised self-checking bench for guess_ctrl against a game-rule reference model.
module tb_guess_ctrl;
    import guess_pkg::*;

    localparam int MAXT = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start;
    logic       btn_guess;
    logic [4:0] sw_guess;
    logic [1:0] state;
    logic [4:0] userguess;
    logic [4:0] RnG;
    logic [2:0] triesLED;

    int errors = 0;
    int checks = 0;
    int edge_cnt;

    // Reference game model
    logic [1:0]  m_state;
    logic [4:0]  m_guess;
    logic [4:0]  m_rng;
    int          m_tries;
    logic [4:0]  exp_lfsr;
    logic [14:0] early_bus;
    logic [14:0] prev_bus;
    logic [14:0] mid_bus;
    logic [4:0]  lfsr_seq [31];

    always #5 clk = ~clk;

    guess_ctrl #(.MAX_TRIES(MAXT), .LFSR_SEED(5'b00001)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_guess (btn_guess),
        .sw_guess  (sw_guess),
        .state     (state),
        .userguess (userguess),
        .RnG       (RnG),
        .triesLED  (triesLED)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    // Game invariants, observed once per cycle away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (int'(triesLED) > MAXT || (state == ST_LOSE && triesLED != 3'd0) ||
                (state == ST_WIN && userguess != RnG)) begin
                errors++;
                $display("FAIL invariant: state=%0d tries=%0d guess=%0d rng=%0d",
                         state, triesLED, userguess, RnG);
            end
        end
    end

    // Secret sequence from the recurrence of x^5+x^3+1 (period 31, seed 1).
    function automatic logic [4:0] lfsr_after(input int n);
        return lfsr_seq[n % 31];
    endfunction

    function automatic logic [14:0] model_bus();
        return {m_state, m_guess, m_rng, 3'(m_tries)};
    endfunction

    function automatic logic [14:0] dut_bus();
        return {state, userguess, RnG, triesLED};
    endfunction

    task automatic model_reset();
        m_state = ST_IDLE; m_guess = 5'd0; m_rng = 5'd0; m_tries = MAXT;
    endtask

    // Drives one button press and advances the reference model at the 3rd edge.
    task automatic press(input bit s, input bit g, input logic [4:0] sw, input int hold);
        @(negedge clk);
        sw_guess = sw;
        repeat (3) @(negedge clk);
        btn_start = s;
        btn_guess = g;
        prev_bus = model_bus();
        @(posedge clk); @(posedge clk); #1;
        early_bus = dut_bus();
        @(posedge clk); #1;
        exp_lfsr = lfsr_after(edge_cnt - 1);
        if (s) begin
            if (m_state == ST_IDLE) begin
                m_rng = exp_lfsr; m_tries = MAXT; m_guess = 5'd0; m_state = ST_PLAY;
            end else begin
                m_state = ST_IDLE; m_tries = MAXT;
            end
        end else if (g && m_state == ST_PLAY) begin
            m_guess = sw;
            if (sw == m_rng) m_state = ST_WIN;
            else if (m_tries == 1) begin m_tries = 0; m_state = ST_LOSE; end
            else m_tries = m_tries - 1;
        end
        mid_bus = dut_bus();
        repeat (hold) @(negedge clk);
        @(negedge clk);
        btn_start = 1'b0;
        btn_guess = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        #7;
        checks++;
        if (dut_bus() !== {2'b00, 5'd0, 5'd0, 3'd5}) begin
            errors++; $display("FAIL reset_outputs: got %h want %h", dut_bus(), {2'b00, 5'd0, 5'd0, 3'd5});
        end
        checks++;
        if (dut.lfsr_reg !== 5'b00001) begin
            errors++; $display("FAIL reset_lfsr: got %b want 00001", dut.lfsr_reg);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_start_latency();
        repeat ($urandom_range(0, 40)) @(negedge clk);
        press(1, 0, 5'($urandom), 20);
        $display("start: rng=%0d tries=%0d state=%0d", RnG, triesLED, state);
        checks++;
        if (early_bus !== prev_bus) begin
            errors++; $display("FAIL start_early: got %h want %h", early_bus, prev_bus);
        end
        checks++;
        if (mid_bus !== model_bus()) begin
            errors++; $display("FAIL start_edge3: got %h want %h", mid_bus, model_bus());
        end
        checks++;
        if (RnG === 5'd0) begin
            errors++; $display("FAIL start_rng_nonzero: got %0d want 1..31", RnG);
        end
        checks++;
        if (dut_bus() !== model_bus()) begin
            errors++; $display("FAIL start_held: got %h want %h", dut_bus(), model_bus());
        end
    endtask

    task automatic test_win();
        press(0, 1, m_rng - 5'd1, 0);
        $display("win wrong guess: guess=%0d tries=%0d state=%0d", userguess, triesLED, state);
        checks++;
        if (dut_bus() !== model_bus() || triesLED !== 3'd4) begin
            errors++; $display("FAIL win_wrong: got %h want %h", dut_bus(), model_bus());
        end
        press(0, 1, m_rng, 0);
        $display("win right guess: guess=%0d tries=%0d state=%0d", userguess, triesLED, state);
        checks++;
        if (dut_bus() !== model_bus() || state !== ST_WIN || triesLED !== 3'd4) begin
            errors++; $display("FAIL win_right: got %h want %h", dut_bus(), model_bus());
        end
        press(0, 1, 5'($urandom), 0);
        $display("win ignored guess: state=%0d", state);
        checks++;
        if (dut_bus() !== model_bus()) begin
            errors++; $display("FAIL win_ignore: got %h want %h", dut_bus(), model_bus());
        end
    endtask

    task automatic test_restart();
        press(1, 0, 5'd0, 0);
        $display("restart to idle: state=%0d tries=%0d", state, triesLED);
        checks++;
        if (dut_bus() !== model_bus() || state !== ST_IDLE) begin
            errors++; $display("FAIL restart_idle: got %h want %h", dut_bus(), model_bus());
        end
        repeat ($urandom_range(1, 30)) @(negedge clk);
        press(1, 0, 5'd0, 0);
        $display("restart to play: rng=%0d tries=%0d", RnG, triesLED);
        checks++;
        if (RnG !== exp_lfsr || dut_bus() !== model_bus()) begin
            errors++; $display("FAIL restart_play: got %h want %h", dut_bus(), model_bus());
        end
    endtask

    task automatic test_lose();
        logic [4:0] w;
        for (int i = 0; i < 6; i++) begin
            w = 5'($urandom);
            if (w == m_rng) w = w ^ 5'h01;
            press(0, 1, w, 0);
            $display("lose guess %0d: guess=%0d tries=%0d state=%0d", i, userguess, triesLED, state);
            checks++;
            if (dut_bus() !== model_bus()) begin
                errors++; $display("FAIL lose_step%0d: got %h want %h", i, dut_bus(), model_bus());
            end
        end
        checks++;
        if (state !== ST_LOSE || triesLED !== 3'd0) begin
            errors++; $display("FAIL lose_final: got state=%0d tries=%0d want 3/0", state, triesLED);
        end
    endtask

    task automatic test_abort();
        press(1, 0, 5'd0, 0);
        press(1, 0, 5'd0, 0);
        press(0, 1, m_rng ^ 5'h02, 0);
        press(0, 1, m_rng ^ 5'h04, 0);
        checks++;
        if (dut_bus() !== model_bus() || triesLED !== 3'd3) begin
            errors++; $display("FAIL abort_setup: got %h want %h", dut_bus(), model_bus());
        end
        press(1, 1, m_rng, 0);
        $display("abort: state=%0d tries=%0d guess=%0d", state, triesLED, userguess);
        checks++;
        if (dut_bus() !== model_bus() || state !== ST_IDLE || triesLED !== 3'd5) begin
            errors++; $display("FAIL abort_priority: got %h want %h", dut_bus(), model_bus());
        end
    endtask

    task automatic test_back_to_back();
        bit s, g;
        logic [4:0] w;
        for (int i = 0; i < 30; i++) begin
            s = ($urandom_range(0, 3) == 0);
            g = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 2) == 0) ? m_rng : 5'($urandom);
            press(s, g, w, $urandom_range(0, 3));
            $display("random %0d: s=%0d g=%0d sw=%0d -> state=%0d guess=%0d rng=%0d tries=%0d",
                     i, s, g, w, state, userguess, RnG, triesLED);
            checks++;
            if (dut_bus() !== model_bus()) begin
                errors++; $display("FAIL random%0d: got %h want %h", i, dut_bus(), model_bus());
            end
        end
    endtask

    task automatic test_reset_midgame();
        for (int i = 0; i < 2 && m_state != ST_PLAY; i++) press(1, 0, 5'd0, 0);
        press(0, 1, m_rng ^ 5'h08, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        $display("midgame reset: state=%0d tries=%0d", state, triesLED);
        checks++;
        if (dut_bus() !== {2'b00, 5'd0, 5'd0, 3'd5}) begin
            errors++; $display("FAIL midreset_outputs: got %h want %h", dut_bus(), {2'b00, 5'd0, 5'd0, 3'd5});
        end
        checks++;
        if (dut.lfsr_reg !== 5'b00001) begin
            errors++; $display("FAIL midreset_lfsr: got %b want 00001", dut.lfsr_reg);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        press(1, 0, 5'd0, 0);
        checks++;
        if (dut_bus() !== model_bus()) begin
            errors++; $display("FAIL midreset_restart: got %h want %h", dut_bus(), model_bus());
        end
    endtask

    initial begin
        logic [4:0] v;
        v = 5'b00001;
        for (int i = 0; i < 31; i++) begin
            lfsr_seq[i] = v;
            v = {v[3:0], v[4] ^ v[2]};
        end
        reset = 1'b1;
        btn_start = 1'b0;
        btn_guess = 1'b0;
        sw_guess = 5'd0;
        model_reset();
        test_reset();
        test_start_latency();
        test_win();
        test_restart();
        test_lose();
        test_abort();
        test_back_to_back();
        test_reset_midgame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
